// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-aware arbiter sharing the FIFO_memory write port among NUM_REQ requesters.
// A winner keeps the port until its last beat or until MAX_BURST beats, whichever comes first.
module fifo_write_arbiter #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned IdW      = $clog2(NUM_REQ)
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wfull,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic                         wclk_en,
  output logic [IdW-1:0]               grant_id,
  output logic                         burst_err
);

  localparam int unsigned CntW = $clog2(MAX_BURST);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  owner_q, owner_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic            burst_err_q, burst_err_d;

  logic [DATA_SIZE-1:0] data_arr [NUM_REQ];
  logic [IdW:0]         cand;
  logic                 win_found;
  logic [IdW-1:0]       win_id;
  logic                 sel_vld;
  logic [IdW-1:0]       sel_id;
  logic [IdW-1:0]       sel_inc;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(NUM_REQ)) begin
        cand = cand - (IdW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IdW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IdW-1:0];
      end
    end
  end

  assign sel_vld = (state_q == StLocked) || win_found;
  assign sel_id  = (state_q == StLocked) ? owner_q : win_id;
  assign sel_inc = (sel_id == IdW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;

  always_comb begin
    req_ready = '0;
    wclk_en   = 1'b0;
    wdata     = '0;
    grant_id  = '0;
    if (!wrst && sel_vld) begin
      req_ready[sel_id] = !wfull;
      wclk_en           = req_valid[sel_id] && !wfull;
      wdata             = data_arr[sel_id];
      grant_id          = sel_id;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = 1'b0;
    if (wclk_en) begin
      if (req_last[sel_id]) begin
        state_d    = StIdle;
        rr_ptr_d   = sel_inc;
        beat_cnt_d = '0;
      end else if (state_q == StIdle) begin
        state_d    = StLocked;
        owner_d    = sel_id;
        beat_cnt_d = CntW'(1);
      end else if (beat_cnt_q == CntW'(MAX_BURST - 1)) begin
        // Burst limit reached without a last beat: release and flag it.
        state_d     = StIdle;
        rr_ptr_d    = sel_inc;
        beat_cnt_d  = '0;
        burst_err_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign burst_err = burst_err_q;

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin, packet-aware arbiter that shares the single write port of FIFO_memory among NUM_REQ requesters on the write clock domain. It drives wdata and the write enable (wclk_en) directly into the memory. It honours wfull so that no write is issued while the FIFO is full. Once a requester wins, it keeps the port until its packet ends (req_last) or until its burst limit expires.

Parameters:
DATA_SIZE, 8, width of one FIFO word
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, maximum beats per grant before a forced release (2..256)

Ports:
wclk  in  1  write-domain clock; all state updates on rising edge
wrst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_SIZE  packed beat data; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE]
req_last  in  NUM_REQ  per-requester last-beat-of-packet flag
req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid&&ready
wfull  in  1  FIFO full flag (write domain)
wdata  out  DATA_SIZE  data to FIFO_memory
wclk_en  out  1  write strobe to FIFO_memory; high exactly on transfer cycles
grant_id  out  clog2(NUM_REQ)  index of requester being written this cycle
burst_err  out  1  one-cycle pulse on forced release

Behaviour:
- State registers: state {IDLE, LOCKED}, owner, rr_ptr, beat_cnt, burst_err.
  - Reset values: IDLE, 0, 0, 0, 0.
- While wrst is high, req_ready=0, wclk_en=0, wdata=0 and grant_id=0, regardless of inputs.
- Winner in IDLE: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ. Computed combinationally.
- Selected requester (sel):
  - IDLE: the winner.
  - LOCKED: owner.
  - No valid requester in IDLE: no selection.
- Combinational outputs, zero latency:
  - req_ready[sel] = !wfull.
  - All other ready bits are 0.
  - wclk_en = req_valid[sel] && !wfull.
  - wdata = req_data[sel].
  - grant_id = sel (0 when there is no selection).
- Transfer (xfer) = wclk_en.
- IDLE transitions:
  - xfer with req_last[sel]=1: stay IDLE; rr_ptr <= sel+1 mod NUM_REQ.
  - xfer with last=0: go LOCKED; owner <= sel; beat_cnt <= 1.
  - No xfer (no valid requester, or wfull): nothing changes; rr_ptr does not move.
- LOCKED transitions:
  - Only owner can transfer; other requesters see ready=0 even when valid.
  - xfer with last=1: go IDLE; rr_ptr <= owner+1; beat_cnt <= 0.
  - xfer with last=0 and beat_cnt==MAX_BURST-1: forced release. Go IDLE; rr_ptr <= owner+1; beat_cnt <= 0; burst_err=1 for the next cycle only.
  - xfer otherwise: beat_cnt++.
  - Owner's valid low, or wfull: hold state and beat_cnt; wclk_en=0.
- Requester rule: once valid is asserted, data and last are held stable until ready. The arbiter does not check this rule.
- wfull rising mid-packet: the beat in that cycle is not written; the grant is held; the beat resumes when wfull falls.
- Wrap-around: rr_ptr wraps NUM_REQ-1 -> 0. owner+1 wraps the same way.
- Asynchronous reset mid-packet: the partial packet is abandoned and all state is cleared immediately. The bench must not expect completion.
- Throughput: one beat per clock when no backpressure is applied.
- wdata/wclk_en feed the memory's registered write at the same wclk edge. No extra pipeline stage.

Test Plan:
1. Reset: assert wrst with all req_valid=1 -> req_ready=0, wclk_en=0, grant_id=0. After release, first grant is requester 0.
2. Fairness: requesters 0 and 2 send continuous single-beat packets (last=1), data 0xA0.. and 0xC0.. -> grant_id sequence 0,2,0,2…, wclk_en=1 every cycle, wdata alternates.
3. Packet lock: requester 1 sends 4 beats 0x11..0x14 (last on 4th) while requester 3 is valid -> four consecutive writes from requester 1, then requester 3. req_ready[3]=0 during the packet.
4. Backpressure: wfull=1 for 3 cycles after beat 2 of a 4-beat packet -> wclk_en=0 for those 3 cycles, owner unchanged, beats 3-4 written after wfull drops. No lost or duplicated words.
5. Burst limit: MAX_BURST=4, requester 2 sends 6 beats with no last -> 4 writes, burst_err pulses one cycle, rr_ptr=3. Requester 2 is re-arbitrated for its remaining 2 beats.
6. Async reset mid-LOCKED (after 2 beats), wrst asserted between clock edges -> wclk_en/req_ready drop to 0 immediately, state IDLE, rr_ptr=0, beat_cnt=0.
